// File: rtl/fixed_to_float_pipe.sv
// fixed_to_float_pipe: signed fixed-point to IEEE-754 single precision.
// Three register stages (magnitude, normalise, round) under one global stall.
module fixed_to_float_pipe #(
  parameter int p_WIDTH     = 32,
  parameter int p_FRAC_BITS = 0
) (
  input  logic               i_CLK,
  input  logic               i_RST_N,
  input  logic               i_VALID,
  output logic               o_READY,
  input  logic [p_WIDTH-1:0] i_FIXED_WORD,
  input  logic               i_ROUND_MODE,
  output logic               o_VALID,
  input  logic               i_READY,
  output logic [31:0]        o_FLOAT_WORD,
  output logic               o_ZERO,
  output logic               o_INEXACT
);

  // Biased exponent when the leading one sits at bit p_WIDTH-1.
  localparam int EXP_TOP = 127 + p_WIDTH - 1 - p_FRAC_BITS;
  localparam int LZ_W    = 7;

  logic               s1_valid;
  logic               s1_sign;
  logic               s1_rnd;
  logic [p_WIDTH-1:0] s1_mag;

  logic               s2_valid;
  logic               s2_sign;
  logic               s2_rnd;
  logic               s2_zero;
  logic [p_WIDTH-2:0] s2_norm;
  logic [7:0]         s2_exp;

  logic [LZ_W-1:0]    lz;
  logic [p_WIDTH-1:0] shifted;
  logic [7:0]         exp_c;

  logic [p_WIDTH+23:0] ext;
  logic [22:0]         mant;
  logic                guard;
  logic                sticky;
  logic                inc;
  logic [23:0]         mant_sum;
  logic [7:0]          exp_r;

  // Every stage advances together whenever the output slot is free or being drained.
  assign o_READY = !o_VALID || i_READY;

  // Stage 1 valid: cleared by reset, otherwise follows the input handshake.
  always_ff @(posedge i_CLK) begin
    if (!i_RST_N) begin
      s1_valid <= 1'b0;
    end else if (o_READY) begin
      s1_valid <= i_VALID;
    end
  end

  // Stage 1 data: sign, rounding mode and magnitude; -2^(W-1) negates to itself, read as unsigned.
  always_ff @(posedge i_CLK) begin
    if (o_READY) begin
      s1_sign <= i_FIXED_WORD[p_WIDTH-1];
      s1_rnd  <= i_ROUND_MODE;
      s1_mag  <= i_FIXED_WORD[p_WIDTH-1] ? -i_FIXED_WORD : i_FIXED_WORD;
    end
  end

  // Leading-zero count, normalising shift and exponent for the stage 2 register.
  always_comb begin
    lz = '0;
    for (int i = 0; i < p_WIDTH; i++) begin
      if (s1_mag[i]) lz = LZ_W'(p_WIDTH - 1 - i);
    end
    shifted = s1_mag << lz;
    exp_c   = 8'(EXP_TOP - int'(lz));
  end

  // Stage 2 valid.
  always_ff @(posedge i_CLK) begin
    if (!i_RST_N) begin
      s2_valid <= 1'b0;
    end else if (o_READY) begin
      s2_valid <= s1_valid;
    end
  end

  // Stage 2 data: the hidden one is dropped; its absence after the shift means a zero input.
  always_ff @(posedge i_CLK) begin
    if (o_READY) begin
      s2_sign <= s1_sign;
      s2_rnd  <= s1_rnd;
      s2_zero <= ~shifted[p_WIDTH-1];
      s2_norm <= shifted[p_WIDTH-2:0];
      s2_exp  <= exp_c;
    end
  end

  // Mantissa extraction and round-to-nearest-even; narrow inputs zero-extend via the padding.
  always_comb begin
    ext      = {s2_norm, 25'd0};
    mant     = ext[p_WIDTH+23 -: 23];
    guard    = ext[p_WIDTH];
    sticky   = |ext[p_WIDTH-1:0];
    inc      = s2_rnd && guard && (sticky || mant[0]);
    mant_sum = {1'b0, mant} + 24'(inc);
    exp_r    = s2_exp + 8'(mant_sum[23]);
  end

  // Output register: result fields only load with a real sample so they hold through bubbles.
  always_ff @(posedge i_CLK) begin
    if (!i_RST_N) begin
      o_VALID      <= 1'b0;
      o_FLOAT_WORD <= 32'd0;
      o_ZERO       <= 1'b0;
      o_INEXACT    <= 1'b0;
    end else if (o_READY) begin
      o_VALID <= s2_valid;
      if (s2_valid) begin
        o_ZERO       <= s2_zero;
        o_INEXACT    <= !s2_zero && (guard || sticky);
        o_FLOAT_WORD <= s2_zero ? 32'd0 : {s2_sign, exp_r, mant_sum[22:0]};
      end
    end
  end

endmodule

// File: tb/tb_fixed_to_float_pipe.sv
// Bench for fixed_to_float_pipe: scoreboarded W=32/F=0 instance plus small
// direct checks on W=32/F=16 and W=16/F=8 instances.
module tb_fixed_to_float_pipe;

  logic i_CLK = 1'b0;
  always #5 i_CLK = ~i_CLK;

  logic rst_n;

  logic        a_valid, a_oready, a_rnd, a_ovalid, a_iready, a_zero, a_inex;
  logic [31:0] a_word, a_out;
  logic        b_valid, b_oready, b_rnd, b_ovalid, b_iready, b_zero, b_inex;
  logic [31:0] b_word, b_out;
  logic        c_valid, c_oready, c_rnd, c_ovalid, c_iready, c_zero, c_inex;
  logic [15:0] c_word;
  logic [31:0] c_out;

  fixed_to_float_pipe #(.p_WIDTH(32), .p_FRAC_BITS(0)) u_dut (
    .i_CLK(i_CLK), .i_RST_N(rst_n), .i_VALID(a_valid), .o_READY(a_oready),
    .i_FIXED_WORD(a_word), .i_ROUND_MODE(a_rnd), .o_VALID(a_ovalid), .i_READY(a_iready),
    .o_FLOAT_WORD(a_out), .o_ZERO(a_zero), .o_INEXACT(a_inex));

  fixed_to_float_pipe #(.p_WIDTH(32), .p_FRAC_BITS(16)) u_dut_f16 (
    .i_CLK(i_CLK), .i_RST_N(rst_n), .i_VALID(b_valid), .o_READY(b_oready),
    .i_FIXED_WORD(b_word), .i_ROUND_MODE(b_rnd), .o_VALID(b_ovalid), .i_READY(b_iready),
    .o_FLOAT_WORD(b_out), .o_ZERO(b_zero), .o_INEXACT(b_inex));

  fixed_to_float_pipe #(.p_WIDTH(16), .p_FRAC_BITS(8)) u_dut_w16 (
    .i_CLK(i_CLK), .i_RST_N(rst_n), .i_VALID(c_valid), .o_READY(c_oready),
    .i_FIXED_WORD(c_word), .i_ROUND_MODE(c_rnd), .o_VALID(c_ovalid), .i_READY(c_iready),
    .o_FLOAT_WORD(c_out), .o_ZERO(c_zero), .o_INEXACT(c_inex));

  typedef struct packed {
    logic [31:0] word;
    logic        zero;
    logic        inex;
  } res_t;

  typedef struct {
    logic [31:0] w;
    logic        r;
    res_t        e;
  } vec_t;

  int   n_vec = 0;
  int   n_err = 0;
  res_t sb[$];
  res_t cur;
  vec_t tbl[$];
  int   rdy_mode = 0;   // 0 always ready, 1 fixed pattern, 2 random, 3 manual
  int   pat_i = 0;
  logic [5:0] pat = 6'b101001;   // i_READY sequence 1,0,0,1,0,1 from bit 0 upward

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Independent reference for W=32, F=0: rounding decided by comparing the
  // discarded remainder against one half ulp.
  function automatic res_t ref_conv(input logic [31:0] w, input logic rnd);
    res_t        r;
    logic [31:0] mag, q, rem, half;
    logic        s, inc, inex;
    int          p, sh;
    s = w[31];
    mag = s ? (~w + 32'd1) : w;
    r.word = 32'd0; r.zero = 1'b1; r.inex = 1'b0;
    if (mag == 32'd0) return r;
    p = 0;
    for (int i = 0; i < 32; i++) if (mag[i]) p = i;
    inex = 1'b0;
    if (p <= 23) begin
      q = mag << (23 - p);
    end else begin
      sh   = p - 23;
      q    = mag >> sh;
      rem  = mag & ((32'd1 << sh) - 32'd1);
      half = 32'd1 << (sh - 1);
      inex = (rem != 32'd0);
      inc  = rnd && ((rem > half) || ((rem == half) && q[0]));
      q    = q + 32'(inc);
      if (q[24]) begin
        q = q >> 1;
        p++;
      end
    end
    r.word = {s, 8'(127 + p), q[22:0]};
    r.zero = 1'b0;
    r.inex = inex;
    return r;
  endfunction

  function automatic void add(input logic [31:0] w, input logic r, input logic [31:0] e,
                              input logic z, input logic i);
    vec_t v;
    v.w = w; v.r = r; v.e.word = e; v.e.zero = z; v.e.inex = i;
    tbl.push_back(v);
  endfunction

  // Ready generator, updated just after each rising edge.
  initial forever begin
    @(posedge i_CLK);
    #2;
    case (rdy_mode)
      0: a_iready = 1'b1;
      1: begin a_iready = pat[pat_i]; pat_i = (pat_i + 1) % 6; end
      2: a_iready = 1'($urandom_range(0, 1));
      default: ;
    endcase
  end

  // Monitor / scoreboard on the falling edge: decides what the next rising edge transfers.
  res_t held, got, want;
  logic stall_prev = 1'b0;
  initial forever begin
    @(negedge i_CLK);
    if (!rst_n) begin
      sb.delete();
      stall_prev = 1'b0;
    end else begin
      got = {a_out, a_zero, a_inex};
      if (stall_prev) chk("stall_hold", 64'({a_ovalid, got}), 64'({1'b1, held}));
      chk("o_ready", 64'(a_oready), 64'(!a_ovalid || a_iready));
      if (a_ovalid && a_iready) begin
        if (sb.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_output: got %h, expected no output", a_out);
        end else begin
          want = sb.pop_front();
          chk("result", 64'(got), 64'(want));
        end
      end
      if (a_valid && a_oready) sb.push_back(cur);
      stall_prev = a_ovalid && !a_iready;
      held = got;
    end
  end

  task automatic send(input logic [31:0] w, input logic r, input res_t e);
    int   n;
    logic ok;
    a_word = w; a_rnd = r; cur = e; a_valid = 1'b1; n = 0;
    do begin
      @(negedge i_CLK);
      ok = a_oready;
      @(posedge i_CLK); #1;
      n++;
    end while (!ok && n < 200);
    a_valid = 1'b0;
    if (!ok) begin
      n_vec++; n_err++;
      $display("FAIL send_timeout: got no acceptance of %h, expected within 200 cycles", w);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(posedge i_CLK); n++;
    end
    #1;
    chk("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  task automatic run_b(input logic [31:0] w, input logic [31:0] e);
    int n;
    b_word = w; b_valid = 1'b1;
    @(posedge i_CLK); #1;
    b_valid = 1'b0; n = 1;
    while (!b_ovalid && n < 10) begin @(posedge i_CLK); #1; n++; end
    chk("f16_word", 64'(b_out), 64'(e));
    chk("f16_latency", 64'(n), 64'd3);
  endtask

  task automatic run_c(input logic [15:0] w, input logic [31:0] e);
    int n;
    c_word = w; c_valid = 1'b1;
    @(posedge i_CLK); #1;
    c_valid = 1'b0; n = 1;
    while (!c_ovalid && n < 10) begin @(posedge i_CLK); #1; n++; end
    chk("w16_word", 64'(c_out), 64'(e));
    chk("w16_latency", 64'(n), 64'd3);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion, expected finish before 1 ms");
    $fatal(1);
  end

  initial begin
    logic [31:0] w;
    logic        r;
    int          lat;
    rst_n = 1'b0;
    a_valid = 1'b0; a_word = '0; a_rnd = 1'b1; a_iready = 1'b1;
    b_valid = 1'b0; b_word = '0; b_rnd = 1'b1; b_iready = 1'b1;
    c_valid = 1'b0; c_word = '0; c_rnd = 1'b1; c_iready = 1'b1;
    cur = '0;

    add(32'h00000001, 1, 32'h3F800000, 0, 0);
    add(32'hFFFFFFFF, 1, 32'hBF800000, 0, 0);
    add(32'h00000000, 1, 32'h00000000, 1, 0);
    add(32'h80000000, 1, 32'hCF000000, 0, 0);
    add(32'h00000000, 0, 32'h00000000, 1, 0);
    add(32'h01000003, 1, 32'h4B800002, 0, 1);
    add(32'h01000003, 0, 32'h4B800001, 0, 1);
    add(32'h01000001, 1, 32'h4B800000, 0, 1);
    add(32'h01000002, 1, 32'h4B800001, 0, 0);
    add(32'h01000005, 1, 32'h4B800002, 0, 1);
    add(32'h01000007, 1, 32'h4B800004, 0, 1);
    add(32'h02000003, 1, 32'h4C000001, 0, 1);
    add(32'h02000003, 0, 32'h4C000000, 0, 1);
    add(32'h7FFFFFFF, 1, 32'h4F000000, 0, 1);
    add(32'h7FFFFFFF, 0, 32'h4EFFFFFF, 0, 1);
    add(32'h7FFFFFFF, 1, 32'h4F000000, 0, 1);
    add(32'h80000001, 1, 32'hCF000000, 0, 1);
    add(32'h80000001, 0, 32'hCEFFFFFF, 0, 1);
    add(32'hFEFFFFFD, 1, 32'hCB800002, 0, 1);
    add(32'h00000003, 0, 32'h40400000, 0, 0);
    add(32'h00800000, 1, 32'h4B000000, 0, 0);
    add(32'h01000001, 0, 32'h4B800000, 0, 1);

    // Reset state
    repeat (2) @(posedge i_CLK);
    #1;
    chk("rst_o_valid", 64'(a_ovalid), 64'd0);
    chk("rst_o_word", 64'(a_out), 64'd0);
    chk("rst_o_flags", 64'({a_zero, a_inex}), 64'd0);
    chk("rst_f16_valid", 64'(b_ovalid), 64'd0);
    chk("rst_w16_valid", 64'(c_ovalid), 64'd0);
    rst_n = 1'b1;
    @(posedge i_CLK); #1;
    chk("o_ready_after_rst", 64'(a_oready), 64'd1);

    // Table vectors, back-to-back with i_READY held high
    rdy_mode = 0;
    foreach (tbl[k]) send(tbl[k].w, tbl[k].r, tbl[k].e);
    drain();

    // Backpressure pattern with six streamed samples
    pat_i = 0;
    rdy_mode = 1;
    for (int k = 0; k < 6; k++) begin
      w = 32'h01000001 + 32'(k * 7) + (32'(k) << 27);
      r = 1'(k);
      send(w, r, ref_conv(w, r));
    end
    drain();

    // Random words, random rounding, random ready and input gaps
    rdy_mode = 2;
    for (int k = 0; k < 80; k++) begin
      w = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) w = -w;
      r = 1'($urandom_range(0, 1));
      send(w, r, ref_conv(w, r));
      repeat ($urandom_range(0, 1)) begin @(posedge i_CLK); #1; end
    end
    rdy_mode = 0;
    drain();

    // Reset with three samples in flight
    send(32'd11, 1'b1, ref_conv(32'd11, 1'b1));
    send(32'd12, 1'b1, ref_conv(32'd12, 1'b1));
    send(32'd13, 1'b1, ref_conv(32'd13, 1'b1));
    rdy_mode = 3;
    a_iready = 1'b0;
    rst_n = 1'b0;
    @(posedge i_CLK); #1;
    chk("midrst_o_valid", 64'(a_ovalid), 64'd0);
    chk("midrst_o_word", 64'(a_out), 64'd0);
    chk("midrst_o_flags", 64'({a_zero, a_inex}), 64'd0);
    chk("midrst_o_ready", 64'(a_oready), 64'd1);
    rst_n = 1'b1;
    rdy_mode = 0;
    repeat (6) begin @(posedge i_CLK); #1; end
    a_word = 32'hFFFFFFFB; a_rnd = 1'b1; cur = {32'hC0A00000, 1'b0, 1'b0};
    a_valid = 1'b1; lat = 0;
    do begin
      @(posedge i_CLK); #1;
      a_valid = 1'b0;
      lat++;
    end while (!a_ovalid && lat < 10);
    chk("post_rst_latency", 64'(lat), 64'd3);
    drain();

    // Binary-point and narrow-width instances
    run_b(32'h00018000, 32'h3FC00000);
    run_b(32'hFFFF0000, 32'hBF800000);
    run_b(32'h00000001, 32'h37800000);
    run_c(16'h0180, 32'h3FC00000);
    run_c(16'h8000, 32'hC3000000);
    run_c(16'h0001, 32'h3B800000);

    repeat (4) @(posedge i_CLK);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
